// File: rtl/ysyx22041405_wb_pkg.sv
// Shared types and constants for the write-back arbiter and scoreboard.
package ysyx22041405_wb_pkg;

    localparam int unsigned REG_AW = 5;

    // Result source; also the encoding of the round-robin last-grant state.
    typedef enum logic {
        WB_SRC_EXU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/ysyx22041405_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, x0 never pending.
module ysyx22041405_scoreboard
    import ysyx22041405_wb_pkg::*;
#(
    parameter int unsigned NREG = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en_i,
    input  logic [REG_AW-1:0] set_idx_i,
    input  logic              clr_en_i,
    input  logic [REG_AW-1:0] clr_idx_i,
    input  logic [REG_AW-1:0] chk_rs1_i,
    input  logic [REG_AW-1:0] chk_rs2_i,
    output logic              rs1_busy_o,
    output logic              rs2_busy_o
);

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;

    // Clear on register-file commit, then set on issue so a newer producer wins.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_i && (32'(clr_idx_i) < NREG)) begin
            pending_d[clr_idx_i] = 1'b0;
        end
        if (set_en_i && (set_idx_i != '0) && (32'(set_idx_i) < NREG)) begin
            pending_d[set_idx_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Pending vector register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Operand lookups; no bypass, so a register is busy until its commit edge.
    always_comb begin
        rs1_busy_o = 1'b0;
        rs2_busy_o = 1'b0;
        if (32'(chk_rs1_i) < NREG) begin
            rs1_busy_o = pending_q[chk_rs1_i];
        end
        if (32'(chk_rs2_i) < NREG) begin
            rs2_busy_o = pending_q[chk_rs2_i];
        end
    end

endmodule

// File: rtl/ysyx22041405_wb_arbiter.sv
// Write-back controller: round-robin EXU/LSU arbitration onto the single
// register-file write port, registered write outputs, pending-write scoreboard.
module ysyx22041405_wb_arbiter
    import ysyx22041405_wb_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREG  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_rd,
    input  logic [REG_AW-1:0] chk_rs1,
    input  logic [REG_AW-1:0] chk_rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              exu_valid,
    output logic              exu_ready,
    input  logic [REG_AW-1:0] exu_rd,
    input  logic [WIDTH-1:0]  exu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [WIDTH-1:0]  lsu_data,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [WIDTH-1:0]  rf_wdata
);

    wb_src_e           last_grant_q;
    logic              rf_we_q;
    logic [REG_AW-1:0] rf_waddr_q;
    logic [WIDTH-1:0]  rf_wdata_q;
    logic              grant_exu_c;
    logic              grant_lsu_c;

    // Round-robin grant from valids and last winner only; never looks at data.
    always_comb begin
        grant_exu_c = exu_valid && (!lsu_valid || (last_grant_q == WB_SRC_LSU));
        grant_lsu_c = lsu_valid && (!exu_valid || (last_grant_q == WB_SRC_EXU));
    end

    assign exu_ready = grant_exu_c;
    assign lsu_ready = grant_lsu_c;

    // Capture the winning transfer; writes to x0 are accepted but never enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= WB_SRC_LSU;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            rf_we_q <= 1'b0;
            if (grant_exu_c) begin
                last_grant_q <= WB_SRC_EXU;
                rf_we_q      <= (exu_rd != '0);
                rf_waddr_q   <= exu_rd;
                rf_wdata_q   <= exu_data;
            end else if (grant_lsu_c) begin
                last_grant_q <= WB_SRC_LSU;
                rf_we_q      <= (lsu_rd != '0);
                rf_waddr_q   <= lsu_rd;
                rf_wdata_q   <= lsu_data;
            end
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    ysyx22041405_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst),
        .set_en_i   (iss_valid),
        .set_idx_i  (iss_rd),
        .clr_en_i   (rf_we_q),
        .clr_idx_i  (rf_waddr_q),
        .chk_rs1_i  (chk_rs1),
        .chk_rs2_i  (chk_rs2),
        .rs1_busy_o (rs1_busy),
        .rs2_busy_o (rs2_busy)
    );

endmodule

// File: tb/tb_ysyx22041405_wb_arbiter.sv
// Directed bench for the write-back arbiter and scoreboard.
module tb_ysyx22041405_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        exu_valid;
    logic        exu_ready;
    logic [4:0]  exu_rd;
    logic [31:0] exu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int checks;
    int errors;

    ysyx22041405_wb_arbiter #(
        .WIDTH (32),
        .NREG  (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .chk_rs1   (chk_rs1),
        .chk_rs2   (chk_rs2),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .exu_valid (exu_valid),
        .exu_ready (exu_ready),
        .exu_rd    (exu_rd),
        .exu_data  (exu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        chk_rs1   = '0;
        chk_rs2   = '0;
        exu_valid = 1'b0;
        exu_rd    = '0;
        exu_data  = '0;
        lsu_valid = 1'b0;
        lsu_rd    = '0;
        lsu_data  = '0;

        tick();
        tick();
        rst = 1'b1;

        // Build some state: issue rd=3 and an EXU write to rd=5.
        iss_valid = 1'b1; iss_rd = 5'd3;
        exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'h0000_AAAA;
        tick();
        iss_valid = 1'b0; exu_valid = 1'b0; chk_rs1 = 5'd3;
        #1;
        chk("pre_rst_we", 32'(rf_we), 32'd1);
        chk("pre_rst_busy3", 32'(rs1_busy), 32'd1);

        // Asynchronous reset mid-cycle while EXU is requesting.
        #2;
        exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEAD_BEEF;
        rst = 1'b0;
        #1;
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_busy3", 32'(rs1_busy), 32'd0);
        tick();
        tick();
        chk("rst_hold_we", 32'(rf_we), 32'd0);
        rst = 1'b1;
        #1;

        // Single EXU write after reset: EXU wins, lands one cycle later.
        chk("single_exu_ready", 32'(exu_ready), 32'd1);
        chk("single_lsu_ready", 32'(lsu_ready), 32'd0);
        tick();
        exu_valid = 1'b0;
        chk("single_we", 32'(rf_we), 32'd1);
        chk("single_waddr", 32'(rf_waddr), 32'd5);
        chk("single_wdata", rf_wdata, 32'hDEAD_BEEF);
        tick();
        chk("single_we_off", 32'(rf_we), 32'd0);
        chk("single_waddr_hold", 32'(rf_waddr), 32'd5);

        // LSU-only write so LSU becomes last winner.
        lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'h0000_0A0A;
        #1;
        chk("lsu_only_ready", 32'(lsu_ready), 32'd1);
        chk("lsu_only_exu_ready", 32'(exu_ready), 32'd0);
        tick();
        lsu_valid = 1'b0;
        chk("lsu_only_waddr", 32'(rf_waddr), 32'd10);
        chk("lsu_only_wdata", rf_wdata, 32'h0000_0A0A);

        // Contention: expect EXU, LSU, EXU, LSU and waddr 1,3,2,4.
        exu_valid = 1'b1; exu_rd = 5'd1; exu_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h33;
        #1;
        chk("rr0_exu_ready", 32'(exu_ready), 32'd1);
        chk("rr0_lsu_ready", 32'(lsu_ready), 32'd0);
        tick();
        exu_rd = 5'd2; exu_data = 32'h22;
        #1;
        chk("rr1_waddr", 32'(rf_waddr), 32'd1);
        chk("rr1_wdata", rf_wdata, 32'h11);
        chk("rr1_exu_ready", 32'(exu_ready), 32'd0);
        chk("rr1_lsu_ready", 32'(lsu_ready), 32'd1);
        tick();
        lsu_rd = 5'd4; lsu_data = 32'h44;
        #1;
        chk("rr2_waddr", 32'(rf_waddr), 32'd3);
        chk("rr2_wdata", rf_wdata, 32'h33);
        chk("rr2_exu_ready", 32'(exu_ready), 32'd1);
        chk("rr2_lsu_ready", 32'(lsu_ready), 32'd0);
        tick();
        exu_valid = 1'b0;
        #1;
        chk("rr3_waddr", 32'(rf_waddr), 32'd2);
        chk("rr3_exu_ready", 32'(exu_ready), 32'd0);
        chk("rr3_lsu_ready", 32'(lsu_ready), 32'd1);
        tick();
        lsu_valid = 1'b0;
        chk("rr4_we", 32'(rf_we), 32'd1);
        chk("rr4_waddr", 32'(rf_waddr), 32'd4);
        chk("rr4_wdata", rf_wdata, 32'h44);
        tick();
        chk("rr5_we", 32'(rf_we), 32'd0);

        // Scoreboard lifecycle on rd=7, written back by LSU.
        iss_valid = 1'b1; iss_rd = 5'd7; chk_rs1 = 5'd7;
        #1;
        chk("sb_not_yet", 32'(rs1_busy), 32'd0);
        tick();
        iss_valid = 1'b0;
        chk("sb_busy_after_issue", 32'(rs1_busy), 32'd1);
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
        #1;
        chk("sb_lsu_ready", 32'(lsu_ready), 32'd1);
        tick();
        lsu_valid = 1'b0;
        chk("sb_we", 32'(rf_we), 32'd1);
        chk("sb_waddr", 32'(rf_waddr), 32'd7);
        chk("sb_busy_in_we_cycle", 32'(rs1_busy), 32'd1);
        tick();
        chk("sb_we_off", 32'(rf_we), 32'd0);
        chk("sb_free_after_commit", 32'(rs1_busy), 32'd0);

        // Set/clear collision on rd=9: reissue in the commit cycle keeps it busy.
        iss_valid = 1'b1; iss_rd = 5'd9; chk_rs2 = 5'd9;
        tick();
        iss_valid = 1'b0;
        exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h99;
        tick();
        exu_valid = 1'b0;
        chk("col_we", 32'(rf_we), 32'd1);
        chk("col_waddr", 32'(rf_waddr), 32'd9);
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0;
        chk("col_busy", 32'(rs2_busy), 32'd1);
        tick();
        chk("col_busy_hold", 32'(rs2_busy), 32'd1);

        // x0: transfer accepted, no write enable, index 0 never busy.
        exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 32'h1234;
        iss_valid = 1'b1; iss_rd = 5'd0; chk_rs1 = 5'd0;
        #1;
        chk("x0_exu_ready", 32'(exu_ready), 32'd1);
        tick();
        exu_valid = 1'b0; iss_valid = 1'b0;
        chk("x0_we", 32'(rf_we), 32'd0);
        chk("x0_busy", 32'(rs1_busy), 32'd0);
        tick();
        chk("x0_we_after", 32'(rf_we), 32'd0);
        chk("x0_busy9_kept", 32'(rs2_busy), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx22041405_wb_arbiter.md
Name: ysyx22041405_wb_arbiter

Overview:
- Write-back controller for the general-purpose register file.
- Shares the register file's single write port between two result sources, EXU (ALU results) and LSU (load data), using valid/ready handshakes and round-robin priority.
- Registers the winning write into the register file's we/waddr/wdata inputs.
- Keeps a pending-write scoreboard so the IDU can stall on operands that are not yet written back.

Parameters:
- WIDTH, 32, data width of register values.
- NREG, 32, number of architectural registers; register index width is fixed at 5 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- iss_valid  input  1  IDU issues an instruction that writes a register.
- iss_rd  input  5  destination register of the issued instruction.
- chk_rs1  input  5  IDU operand 1 index to check.
- chk_rs2  input  5  IDU operand 2 index to check.
- rs1_busy  output  1  operand 1 has a pending write.
- rs2_busy  output  1  operand 2 has a pending write.
- exu_valid  input  1  EXU result available.
- exu_ready  output  1  EXU result accepted this cycle.
- exu_rd  input  5  EXU destination register.
- exu_data  input  WIDTH  EXU result value.
- lsu_valid  input  1  LSU result available.
- lsu_ready  output  1  LSU result accepted this cycle.
- lsu_rd  input  5  LSU destination register.
- lsu_data  input  WIDTH  LSU load data.
- rf_we  output  1  register file write enable (registered).
- rf_waddr  output  5  register file write address (registered).
- rf_wdata  output  WIDTH  register file write data (registered).

Behaviour:
- Reset (rst=0, asynchronous):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - All pending bits=0.
  - last_grant=LSU, so EXU wins the first contention.
- Arbitration (combinational):
  - Only exu_valid: grant EXU.
  - Only lsu_valid: grant LSU.
  - Both valid: grant the source that is not last_grant.
  - last_grant updates at each edge where a grant occurs; no change when idle.
- Ready signals:
  - exu_ready = grant_exu, lsu_ready = grant_lsu.
  - Each ready depends only on valid signals and state, never on data.
  - At most one ready is high per cycle; both are 0 when the corresponding valid is 0.
- Handshake:
  - A transfer occurs on an edge where valid&&ready.
  - The source must hold valid, rd and data stable until accepted.
  - Dropping valid before acceptance is a protocol violation and is not checked.
- Latency:
  - A transfer accepted at edge N drives rf_we=1 and the captured rd/data throughout cycle N+1.
  - The register file writes at edge N+1.
  - If no transfer occurs at edge N, rf_we=0 in cycle N+1; rf_waddr/rf_wdata hold their previous values.
  - Back-to-back grants give one write per cycle; there are no bubbles.
- rd=0 handling:
  - The transfer is still accepted (ready asserted normally).
  - rf_we stays 0 and the scoreboard is not touched.
- Scoreboard (pending[NREG-1:0]):
  - Set: at an edge where iss_valid && iss_rd!=0, pending[iss_rd]<=1.
  - Clear: at an edge where rf_we=1, pending[rf_waddr]<=0, i.e. on the same edge the register file commits.
  - Set and clear of the same index on the same edge: set wins (a newer producer exists).
  - pending[0] is constant 0.
- Busy outputs:
  - rsX_busy = pending[chk_rsX], combinational; index 0 always reads 0.
  - There is no bypass: a register is busy until the edge that writes it and free in the following cycle, when the register file read returns the new value.
- Out of scope: multiple outstanding writes to the same rd. Issue order guarantees at most one producer per rd; a second issue simply keeps the bit set.

Decomposition:
- Package ysyx22041405_wb_pkg holds:
  - REG_AW=5.
  - Enum wb_src_e {WB_SRC_EXU=0, WB_SRC_LSU=1}, used for last_grant and grant encoding.
- Sub-module ysyx22041405_scoreboard holds the pending vector, set/clear logic and the two lookup ports; the arbiter and output register stay in the top module.

Test Plan:
- Reset:
  - Stimulus: hold rst=0 with exu_valid=1 mid-run.
  - Required: rf_we=0, both busy=0 and all pending cleared immediately.
  - After release: first EXU request is granted.
- Single EXU write:
  - Stimulus: exu_valid=1, exu_rd=5, exu_data=0xDEADBEEF accepted at edge N.
  - Required: rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in cycle N+1; rf_we=0 in cycle N+2.
- Contention round-robin:
  - Stimulus: both valid for 4 cycles (EXU rd=1,2; LSU rd=3,4).
  - Required: grant order EXU, LSU, EXU, LSU; rf_waddr sequence 1,3,2,4; never both ready.
- Scoreboard lifecycle:
  - Stimulus: issue rd=7, check rs1=7 (busy=1), then LSU writes rd=7.
  - Required: busy stays 1 through the rf_we cycle and reads 0 in the cycle after.
- Set/clear collision:
  - Stimulus: rf_we committing rd=9 on the same edge as iss_valid with iss_rd=9.
  - Required: pending[9] remains 1.
- x0 write:
  - Stimulus: exu_rd=0 with data 0x1234; also iss_rd=0.
  - Required: exu_ready=1, rf_we stays 0, busy for index 0 stays 0.
